lfsr_arbiter: RTL and testbench
===============================

# lfsr_arbiter

Sequencer and two-way round-robin arbiter for the shared 4-bit `lfsr` datapath. Two requesters each supply a seed and a bit count. The block grants one of them, loads the seed into the LFSR, and collects the requested number of serial `q` bits into a parallel word. It then returns the word with a one-cycle done pulse. It sits between the LFSR instance and its client logic and is the only driver of the LFSR's `load` and `seed` inputs.

## Interface
- `WIDTH`, 8: maximum bits per word and width of `data`; legal range 2..16.
- `LW`, 4: width of each length field; must satisfy 2^LW > WIDTH.

- `clk`  in  1  rising-edge clock, shared with the LFSR.
- `rst`  in  1  reset; one clock, asynchronous and active-high. Also ties to the LFSR's `rst`.
- `req`  in  2  per-requester request level; sampled only in IDLE.
- `seed0`, `seed1`  in  4 each  per-requester seed; sampled in the grant cycle.
- `len0`, `len1`  in  LW each  per-requester bit count; sampled in the grant cycle.
- `lfsr_q`  in  1  serial output of the LFSR (its `q`).
- `lfsr_load`  out  1  drives the LFSR `load`.
- `lfsr_seed`  out  4  drives the LFSR `seed`.
- `gnt`  out  2  one-hot grant; held from LOAD through DONE.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  2  one-cycle completion pulse for the granted requester.
- `data`  out  WIDTH  result word; valid when `done` is nonzero and held until the next LOAD.

## Operation
- The FSM has four states: IDLE, LOAD, RUN and DONE.
- IDLE:
  - If `req` is nonzero at the edge, pick the grantee and latch its seed and length. Next state is LOAD.
  - If both requesters are asserted, the round-robin pointer `prio` chooses; otherwise the single requester wins.
  - `prio` is set to the non-granted index at grant.
- Length rule: latched length = `lenX`. A value of 0 or any value above WIDTH is clamped to WIDTH.
- Seed rule: a seed of 4'b0000 is replaced by 4'b0001. This avoids the LFSR's all-zero lock-up.
- LOAD (1 cycle):
  - `lfsr_load`=1 and `lfsr_seed`=latched seed.
  - Bit counter is cleared and the capture register is cleared.
  - Next state is RUN.
- RUN:
  - `lfsr_load`=0 and `lfsr_seed`=0.
  - Each edge shifts `lfsr_q` into the capture register LSB and increments the counter.
  - After the counter reaches the latched length, next state is DONE.
  - Word packing: the first captured bit lands at bit len-1, the last at bit 0, and the upper bits are 0.
- DONE (1 cycle):
  - `done[g]`=1 and `data`=capture register.
  - Next state is IDLE and `gnt` clears.
- `req` changes outside IDLE are ignored. A requester dropping `req` mid-transaction does not abort; the done pulse still occurs.
- A `req` still high in IDLE after DONE is a new transaction, subject to `prio`.
- Reset, asynchronous, any state:
  - The FSM returns to IDLE and `prio`=0.
  - `gnt`, `done`, `busy`, `lfsr_load`, `lfsr_seed`, `data`, the counter and the capture register all go to 0.
  - An in-flight transaction is dropped without a done pulse.

## Timing
- LFSR model:
  - On a load edge, state := seed.
  - `q` = state[2]^state[3], combinational.
  - Each later edge shifts state := {state[2:0], q}.
  - The first valid bit is therefore presented in the first RUN cycle.
- Cycle budget: req high in IDLE cycle c, then LOAD at c+1, RUN at c+2 .. c+1+len, DONE at c+2+len.
- Total latency from request to done is len+2 cycles. Back-to-back service costs len+3 cycles per transaction, including one IDLE cycle.
- `data` updates only on the edge entering DONE. It stays stable during the DONE cycle and all subsequent IDLE cycles.

## Test plan
- Reset:
  - Stimulus: assert `rst` mid-RUN.
  - Required response: all outputs are 0 immediately, with no clock needed, and there is no `done` pulse.
  - After release with `req`=2'b11, requester 0 is granted first.
- Single requester, len 4:
  - Stimulus: `req`=01, `seed0`=4'b1000, `len0`=4.
  - Required response: `done`=01 exactly 6 cycles after the request cycle, with `data`=8'h09.
- Full word:
  - Stimulus: `seed1`=4'b1000, `len1`=0 (clamped to 8).
  - Required response: `done`=10 with `data`=8'h9A; `lfsr_load` is high for exactly one cycle.
- Zero seed:
  - Stimulus: `seed0`=4'b0000, `len0`=4.
  - Required response: `lfsr_seed` shows 4'b0001 during LOAD, and `data`=8'h03.
- Round-robin:
  - Stimulus: hold `req`=11 continuously, with both lengths 2.
  - Required response: grants alternate 0,1,0,1, and each `done` is separated by 5 cycles.
- Mid-transaction drop:
  - Stimulus: deassert `req[1]` during RUN of requester 1's transaction.
  - Required response: `done[1]` still pulses and `req[0]` is not served until the next IDLE.

Source files
------------

// File: rtl/lfsr_arbiter.sv
// Two-way round-robin arbiter and sequencer for the shared 4-bit LFSR.
// Grants a requester, seeds the LFSR, and packs len serial bits into a word.
module lfsr_arbiter #(
  parameter int WIDTH = 8,
  parameter int LW    = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [1:0]       i_req,
  input  logic [3:0]       i_seed0,
  input  logic [3:0]       i_seed1,
  input  logic [LW-1:0]    i_len0,
  input  logic [LW-1:0]    i_len1,
  input  logic             i_lfsr_q,
  output logic             o_lfsr_load,
  output logic [3:0]       o_lfsr_seed,
  output logic [1:0]       o_gnt,
  output logic             o_busy,
  output logic [1:0]       o_done,
  output logic [WIDTH-1:0] o_data
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

  localparam logic [LW-1:0] LP_WIDTH = LW'(WIDTH);

  state_t          r_state;
  logic            r_prio;
  logic [LW-1:0]   r_len;
  logic [LW-1:0]   r_cnt;
  logic [WIDTH-2:0] r_cap;

  logic            w_pick;
  logic [3:0]      w_seed_raw;
  logic [3:0]      w_seed;
  logic [LW-1:0]   w_len_raw;
  logic [LW-1:0]   w_len;
  logic [WIDTH-1:0] w_cap_next;

  // Contention goes to the pointer; a lone requester wins outright.
  assign w_pick     = (i_req == 2'b11) ? r_prio : i_req[1];
  assign w_seed_raw = w_pick ? i_seed1 : i_seed0;
  assign w_len_raw  = w_pick ? i_len1 : i_len0;
  assign w_seed     = (w_seed_raw == 4'b0000) ? 4'b0001 : w_seed_raw;
  assign w_len      = ((w_len_raw == '0) || (w_len_raw > LP_WIDTH)) ? LP_WIDTH : w_len_raw;
  assign w_cap_next = {r_cap, i_lfsr_q};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_prio      <= 1'b0;
      r_len       <= '0;
      r_cnt       <= '0;
      r_cap       <= '0;
      o_lfsr_load <= 1'b0;
      o_lfsr_seed <= 4'b0000;
      o_gnt       <= 2'b00;
      o_busy      <= 1'b0;
      o_done      <= 2'b00;
      o_data      <= '0;
    end else begin
      o_done <= 2'b00;
      case (r_state)
        S_IDLE: begin
          if (|i_req) begin
            o_gnt       <= w_pick ? 2'b10 : 2'b01;
            r_prio      <= ~w_pick;
            r_len       <= w_len;
            o_lfsr_seed <= w_seed;
            o_lfsr_load <= 1'b1;
            o_busy      <= 1'b1;
            r_state     <= S_LOAD;
          end
        end
        S_LOAD: begin
          o_lfsr_load <= 1'b0;
          o_lfsr_seed <= 4'b0000;
          r_cnt       <= '0;
          r_cap       <= '0;
          r_state     <= S_RUN;
        end
        S_RUN: begin
          // Capture starts cleared, so bits above len-1 stay zero.
          r_cap <= w_cap_next[WIDTH-2:0];
          r_cnt <= r_cnt + LW'(1);
          if (r_cnt == r_len - LW'(1)) begin
            o_data  <= w_cap_next;
            o_done  <= o_gnt;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          o_gnt   <= 2'b00;
          o_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr_arbiter.sv
// Directed bench for lfsr_arbiter with a behavioural 4-bit LFSR on its q input.
// Expected words come from hand-stepping the LFSR recurrence.
module tb_lfsr_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req;
  logic [3:0] seed0, seed1;
  logic [3:0] len0, len1;
  logic       lfsr_q;
  logic       lfsr_load;
  logic [3:0] lfsr_seed;
  logic [1:0] gnt;
  logic       busy;
  logic [1:0] done;
  logic [7:0] data;

  logic [3:0] r_lfsr;
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  int n_load;
  int t0, tprev, lat;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign lfsr_q = r_lfsr[2] ^ r_lfsr[3];
  always @(posedge clk or posedge rst) begin
    if (rst)            r_lfsr <= 4'b0000;
    else if (lfsr_load) r_lfsr <= lfsr_seed;
    else                r_lfsr <= {r_lfsr[2:0], lfsr_q};
  end

  lfsr_arbiter #(.WIDTH(8), .LW(4)) dut (
    .i_clk(clk), .i_rst(rst), .i_req(req),
    .i_seed0(seed0), .i_seed1(seed1), .i_len0(len0), .i_len1(len1),
    .i_lfsr_q(lfsr_q), .o_lfsr_load(lfsr_load), .o_lfsr_seed(lfsr_seed),
    .o_gnt(gnt), .o_busy(busy), .o_done(done), .o_data(data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Advance until a done pulse is seen (bounded); lat is measured from t0.
  task automatic wait_done();
    int bound = 0;
    n_load = 0;
    do begin
      if (lfsr_load) n_load++;
      tick();
      bound++;
    end while (done == 2'b00 && bound < 60);
    lat = cyc - t0;
  endtask

  initial begin
    rst = 1'b1; req = 2'b00;
    seed0 = 4'h0; seed1 = 4'h0; len0 = 4'd0; len1 = 4'd0;
    tick(); tick();
    chk("rst_busy", busy, 1'b0);
    chk("rst_gnt", gnt, 2'b00);
    chk("rst_data", data, 8'h00);
    chk("rst_load", lfsr_load, 1'b0);
    rst = 1'b0;
    tick();

    // single requester, len 4
    req = 2'b01; seed0 = 4'b1000; len0 = 4'd4; t0 = cyc;
    tick();
    chk("s_load", lfsr_load, 1'b1);
    chk("s_seed", lfsr_seed, 4'b1000);
    chk("s_gnt", gnt, 2'b01);
    chk("s_busy", busy, 1'b1);
    wait_done();
    req = 2'b00;
    chk("s_lat", lat, 6);
    chk("s_done", done, 2'b01);
    chk("s_data", data, 8'h09);
    tick();
    chk("s_done_clr", done, 2'b00);
    chk("s_data_hold", data, 8'h09);
    chk("s_busy_clr", busy, 1'b0);
    chk("s_gnt_clr", gnt, 2'b00);

    // full word, length 0 clamps to 8
    req = 2'b10; seed1 = 4'b1000; len1 = 4'd0; t0 = cyc;
    wait_done();
    req = 2'b00;
    chk("f_lat", lat, 10);
    chk("f_done", done, 2'b10);
    chk("f_data", data, 8'h9A);
    chk("f_load_cycles", n_load, 1);
    tick();

    // zero seed replaced by 0001
    req = 2'b01; seed0 = 4'b0000; len0 = 4'd4; t0 = cyc;
    tick();
    chk("z_seed", lfsr_seed, 4'b0001);
    chk("z_load", lfsr_load, 1'b1);
    wait_done();
    req = 2'b00;
    chk("z_lat", lat, 6);
    chk("z_data", data, 8'h03);
    tick();

    // reset in the middle of RUN
    req = 2'b01; seed0 = 4'b1000; len0 = 4'd8;
    tick(); tick(); tick();
    req = 2'b00;
    chk("r_busy_pre", busy, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("r_busy", busy, 1'b0);
    chk("r_gnt", gnt, 2'b00);
    chk("r_data", data, 8'h00);
    chk("r_load", lfsr_load, 1'b0);
    chk("r_seed", lfsr_seed, 4'b0000);
    chk("r_done", done, 2'b00);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("r_no_done", done, 2'b00);
    end

    // round robin with both requesters held high
    req = 2'b11; seed0 = 4'b1000; seed1 = 4'b0100; len0 = 4'd2; len1 = 4'd2;
    rst = 1'b0; t0 = cyc; tprev = cyc;
    for (int i = 0; i < 4; i++) begin
      wait_done();
      chk("rr_done", done, (i % 2 == 0) ? 2'b01 : 2'b10);
      chk("rr_gnt", gnt, (i % 2 == 0) ? 2'b01 : 2'b10);
      chk("rr_data", data, (i % 2 == 0) ? 8'h02 : 8'h03);
      chk("rr_gap", cyc - tprev, (i == 0) ? 4 : 5);
      tprev = cyc;
    end
    req = 2'b00;
    tick();

    // requester 1 drops req mid-RUN while requester 0 starts asking
    req = 2'b10; seed1 = 4'b1000; len1 = 4'd4; t0 = cyc;
    tick();
    chk("d_gnt_load", gnt, 2'b10);
    tick();
    req = 2'b01; seed0 = 4'b0000; len0 = 4'd4;
    tick();
    chk("d_gnt_run", gnt, 2'b10);
    chk("d_busy_run", busy, 1'b1);
    wait_done();
    chk("d_lat", lat, 6);
    chk("d_done", done, 2'b10);
    chk("d_data", data, 8'h09);
    chk("d_gnt_done", gnt, 2'b10);
    tick();
    chk("d_gnt_idle", gnt, 2'b00);
    tick();
    chk("d_gnt_next", gnt, 2'b01);
    wait_done();
    req = 2'b00;
    chk("d_done0", done, 2'b01);
    chk("d_data0", data, 8'h03);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
